f_pc_unit: RTL and testbench

F_PC_UNIT -- requirements
Module: f_pc_unit

---
 rtl/npc_pkg.sv | 14 +
 rtl/npc_sel.sv | 57 +++++
 rtl/f_pc_unit.sv | 79 +++++++
 tb/tb_f_pc_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Next-PC select encodings and the default fetch reset address.
package npc_pkg;

  typedef enum logic [2:0] {
    NPC_PC4 = 3'd0,
    NPC_BEQ = 3'd1,
    NPC_BNE = 3'd2,
    NPC_J   = 3'd3,
    NPC_JR  = 3'd4
  } npc_op_e;

  localparam logic [31:0] NPC_PC_RESET = 32'h0000_3000;

endpackage

// File: rtl/npc_sel.sv
// Combinational next-PC selection: branch / jump / register targets and the
// redirect decision taken from the instruction currently in D.
module npc_sel
  import npc_pkg::*;
(
  input  logic [31:0] f_pc,
  input  logic [2:0]  d_npc_op,
  input  logic [31:0] d_pc,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs,
  input  logic        d_cmp_result,
  output logic [31:0] npc,
  output logic        redirect
);

  logic [31:0] seq_target;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] br_offset;

  // Candidate targets; branch offset is the sign-extended word offset.
  always_comb begin
    seq_target = f_pc + 32'd4;
    br_offset  = {{14{d_imm26[15]}}, d_imm26[15:0], 2'b00};
    br_target  = d_pc + 32'd4 + br_offset;
    j_target   = {d_pc[31:28], d_imm26, 2'b00};
  end

  // Redirect decision and target mux; undefined encodings fall through as PC4.
  always_comb begin
    redirect = 1'b0;
    npc      = seq_target;
    case (npc_op_e'(d_npc_op))
      NPC_BEQ: begin
        redirect = d_cmp_result;
        if (d_cmp_result) npc = br_target;
      end
      NPC_BNE: begin
        redirect = ~d_cmp_result;
        if (!d_cmp_result) npc = br_target;
      end
      NPC_J: begin
        redirect = 1'b1;
        npc      = j_target;
      end
      NPC_JR: begin
        redirect = 1'b1;
        npc      = d_rs;
      end
      default: begin
        redirect = 1'b0;
        npc      = seq_target;
      end
    endcase
  end

endmodule

// File: rtl/f_pc_unit.sv
// Fetch-stage PC register with delay-slot redirect from D.
// Optional fetch-address check enabled by defining F_PC_ADDR_CHECK_EN;
// without it f_adel is tied low.
module f_pc_unit
  import npc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = NPC_PC_RESET,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  d_npc_op,
  input  logic [31:0] d_pc,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs,
  input  logic        d_cmp_result,
  output logic [31:0] f_pc,
  output logic [31:0] d_pc8,
  output logic        redirect,
  output logic        f_adel
);

  logic [31:0] npc;
  logic [31:0] pc_d, pc_q;

  // Elaboration-time sanity check of the legal fetch window.
  if (IM_BASE > IM_LIMIT) begin : g_bad_range
    $error("f_pc_unit: IM_BASE above IM_LIMIT");
  end

  npc_sel u_npc_sel (
    .f_pc         (pc_q),
    .d_npc_op     (d_npc_op),
    .d_pc         (d_pc),
    .d_imm26      (d_imm26),
    .d_rs         (d_rs),
    .d_cmp_result (d_cmp_result),
    .npc          (npc),
    .redirect     (redirect)
  );

  // Stall holds the PC; otherwise load the selected next PC.
  always_comb begin
    pc_d = stall ? pc_q : npc;
  end

  // PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= PC_RESET;
    else       pc_q <= pc_d;
  end

  assign f_pc  = pc_q;
  assign d_pc8 = d_pc + 32'd8;

`ifdef F_PC_ADDR_CHECK_EN
  logic adel_d, adel_q;

  // Flag a misaligned or out-of-window next PC; hold during stall.
  always_comb begin
    adel_d = adel_q;
    if (!stall)
      adel_d = (npc[1:0] != 2'b00) || (npc < IM_BASE) || (npc > IM_LIMIT);
  end

  // Address-error flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) adel_q <= 1'b0;
    else       adel_q <= adel_d;
  end

  assign f_adel = adel_q;
`else
  assign f_adel = 1'b0;
`endif

endmodule

// File: tb/tb_f_pc_unit.sv
// Self-checking bench for f_pc_unit: directed cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_f_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  d_npc_op;
  logic [31:0] d_pc;
  logic [25:0] d_imm26;
  logic [31:0] d_rs;
  logic        d_cmp_result;
  logic [31:0] f_pc;
  logic [31:0] d_pc8;
  logic        redirect;
  logic        f_adel;

  f_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .d_npc_op     (d_npc_op),
    .d_pc         (d_pc),
    .d_imm26      (d_imm26),
    .d_rs         (d_rs),
    .d_cmp_result (d_cmp_result),
    .f_pc         (f_pc),
    .d_pc8        (d_pc8),
    .redirect     (redirect),
    .f_adel       (f_adel)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] m_pc;
  logic        m_adel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_taken(input int op, input bit cmp);
    if (op == 1) return cmp;
    if (op == 2) return !cmp;
    if (op == 3 || op == 4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_target(input int op, input logic [31:0] pc,
                                             input logic [25:0] imm, input logic [31:0] rs);
    longint off;
    logic [15:0] imm16;
    imm16 = imm[15:0];
    off   = longint'($signed(imm16)) * 4;
    case (op)
      1, 2:    return 32'(longint'(pc) + 4 + off);
      3:       return (pc & 32'hF000_0000) | (32'(imm) * 32'd4);
      4:       return rs;
      default: return 32'h0;
    endcase
  endfunction

  // Check combinational outputs, advance the model, clock once, check state.
  task automatic step(input string tag);
    bit          tk;
    logic [31:0] nxt;
    #1;
    tk = ref_taken(int'(d_npc_op), d_cmp_result);
    check({tag, ".redirect"}, {31'b0, redirect}, {31'b0, tk});
    check({tag, ".d_pc8"}, d_pc8, d_pc + 32'd8);
    nxt = tk ? ref_target(int'(d_npc_op), d_pc, d_imm26, d_rs) : m_pc + 32'd4;
    if (!stall) begin
      m_pc = nxt;
`ifdef F_PC_ADDR_CHECK_EN
      m_adel = (nxt % 4 != 0) || (nxt < 32'h0000_3000) || (nxt > 32'h0000_6FFC);
`else
      m_adel = 1'b0;
`endif
    end
    @(posedge clk);
    #1;
    check({tag, ".f_pc"}, f_pc, m_pc);
    check({tag, ".f_adel"}, {31'b0, f_adel}, {31'b0, m_adel});
  endtask

  task automatic drive(input int op, input logic [31:0] pc, input logic [25:0] imm,
                       input logic [31:0] rs, input bit cmp, input bit stl);
    d_npc_op     = 3'(op);
    d_pc         = pc;
    d_imm26      = imm;
    d_rs         = rs;
    d_cmp_result = cmp;
    stall        = stl;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 32'h0000_3000, 26'h0, 32'h0, 1'b0, 1'b1);
    m_pc   = 32'h0000_3000;
    m_adel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.f_pc", f_pc, 32'h0000_3000);
    check("reset.f_adel", {31'b0, f_adel}, 32'h0);

    // Reset released while stalled: PC holds, then first enabled edge gives +4.
    @(negedge clk);
    reset = 1'b0;
    step("rel_stall");
    stall = 1'b0;
    step("rel_first");
    check("rel_first.abs", f_pc, 32'h0000_3004);

    // Asynchronous reset pulse in the middle of a cycle.
    step("pre_pulse");
    #2;
    reset = 1'b1;
    #1;
    check("pulse.f_pc", f_pc, 32'h0000_3000);
    check("pulse.f_adel", {31'b0, f_adel}, 32'h0);
    reset = 1'b0;
    m_pc   = 32'h0000_3000;
    m_adel = 1'b0;
    step("pulse_pc4");
    check("pulse_pc4.abs", f_pc, 32'h0000_3004);

    // Branches.
    drive(1, 32'h0000_3008, 26'h000FFFE, 32'h0, 1'b1, 1'b0);
    step("beq_taken");
    check("beq_taken.abs", f_pc, 32'h0000_3004);
    drive(1, 32'h0000_3008, 26'h000FFFE, 32'h0, 1'b0, 1'b0);
    step("beq_not");
    drive(2, 32'h0000_3010, 26'h0000004, 32'h0, 1'b0, 1'b0);
    step("bne_taken");
    check("bne_taken.abs", f_pc, 32'h0000_3024);
    check("bne.d_pc8", d_pc8, 32'h0000_3018);

    // Jumps.
    drive(3, 32'h0000_3000, 26'h0000C10, 32'h0, 1'b0, 1'b0);
    step("j");
    check("j.abs", f_pc, 32'h0000_3040);
    drive(4, 32'h0000_3000, 26'h0, 32'h0000_31F0, 1'b0, 1'b0);
    step("jr");
    check("jr.abs", f_pc, 32'h0000_31F0);

    // Stall with JR pending for three cycles.
    drive(4, 32'h0000_3100, 26'h0, 32'h0000_3400, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("stall_jr");
    check("stall_jr.abs", f_pc, 32'h0000_31F0);
    stall = 1'b0;
    step("stall_drop");
    check("stall_drop.abs", f_pc, 32'h0000_3400);

    // Fetch-address window edges.
    drive(4, 32'h0000_3000, 26'h0, 32'h0000_3002, 1'b0, 1'b0);
    step("jr_misalign");
    drive(4, 32'h0000_3000, 26'h0, 32'h0000_7000, 1'b0, 1'b0);
    step("jr_above");
    drive(4, 32'h0000_3000, 26'h0, 32'h0000_3100, 1'b0, 1'b0);
    step("jr_ok");
    drive(4, 32'h0000_3000, 26'h0, 32'h0000_6FFC, 1'b0, 1'b0);
    step("jr_limit");
    drive(4, 32'h0000_3000, 26'h0, 32'h0000_2FFC, 1'b0, 1'b0);
    step("jr_below");

    // Undefined encodings act as PC4.
    for (int op = 5; op < 8; op++) begin
      drive(op, 32'h0000_3000, 26'h3FFFFFF, 32'h0000_5000, 1'b1, 1'b0);
      step("undef_op");
    end

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] rpc, rrs;
      rpc = 32'h0000_3000 + ($urandom_range(0, 32'hFFF) << 2);
      case ($urandom_range(0, 3))
        0:       rrs = $urandom;
        1:       rrs = 32'h0000_3000 + $urandom_range(0, 32'h3FFF);
        default: rrs = 32'h0000_3000 + ($urandom_range(0, 32'hFFF) << 2);
      endcase
      drive(int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? 32'($urandom) : rpc,
            26'($urandom), rrs, 1'($urandom), $urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
